// File: rtl/hazard_pkg.sv
// Shared constants for the ID-stage hazard scoreboard: decoder latency codes,
// the default register-index width and the source-port numbering.
package hazard_pkg;

  localparam int REG_BITS_DEF = 5;

  // Cycles until a producer's result can be forwarded; LAT_NONE disables tracking.
  typedef enum logic [2:0] {
    LAT_NONE = 3'd0,
    LAT_ALU  = 3'd1,
    LAT_LOAD = 3'd2,
    LAT_SAD  = 3'd3
  } lat_e;

  localparam int SRC_RS = 0;
  localparam int SRC_RT = 1;
  localparam int SRC_RD = 2;

endpackage

// File: rtl/scoreboard_entry.sv
// One register's countdown: reloads on issue, otherwise decrements to zero.
// busy_o is registered from the next-state count so it moves with the counter.
module scoreboard_entry #(
  parameter int LAT_BITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic [LAT_BITS-1:0] load_val_i,
  output logic [LAT_BITS-1:0] cnt_o,
  output logic                busy_o
);

  logic [LAT_BITS-1:0] cnt_d, cnt_q;
  logic                busy_q;

  // A new issue takes priority over the decrement of an older pending write.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - LAT_BITS'(1);
    end
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= (cnt_d != '0);
    end
  end

  assign cnt_o  = cnt_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage RAW/WAW hazard unit built on per-register countdown counters;
// drives the IF/ID hold / ID/EX bubble and a saturating stall counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS  = 32,
  parameter int REG_BITS  = REG_BITS_DEF,
  parameter int MAX_LAT   = 4,
  parameter int LAT_BITS  = 3,
  parameter int NUM_SRC   = 3,
  parameter int PERF_BITS = 16
) (
  input  logic                         Clk,
  input  logic                         Rst_n,
  input  logic                         issue_valid,
  input  logic                         issue_wen,
  input  logic [REG_BITS-1:0]          issue_dst,
  input  logic [LAT_BITS-1:0]          issue_lat,
  input  logic [NUM_SRC-1:0]           src_valid,
  input  logic [NUM_SRC*REG_BITS-1:0]  src_reg,
  input  logic                         flush,
  output logic                         stall,
  output logic                         accept,
  output logic [NUM_REGS-1:0]          busy_mask,
  output logic [PERF_BITS-1:0]         stall_count
);

  localparam logic [LAT_BITS-1:0] MAX_LAT_W = LAT_BITS'(MAX_LAT);

  // Register 0 is hard-wired zero, so its slot is never instantiated.
  logic [LAT_BITS-1:0]  cnt [1:NUM_REGS-1];
  logic [LAT_BITS-1:0]  eff_lat;
  logic [LAT_BITS-1:0]  dst_cnt;
  logic                 raw_any;
  logic                 waw;
  logic                 live;
  logic [PERF_BITS-1:0] stall_cnt_d, stall_cnt_q;

  assign eff_lat = (issue_lat > MAX_LAT_W) ? MAX_LAT_W : issue_lat;

  // All hazard checks look at pre-update counters, so self-dependency sees the old write.
  always_comb begin
    raw_any = 1'b0;
    dst_cnt = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (issue_dst == REG_BITS'(r)) dst_cnt = cnt[r];
      for (int i = 0; i < NUM_SRC; i++) begin
        if (src_valid[i] && (src_reg[i*REG_BITS +: REG_BITS] == REG_BITS'(r)) &&
            (cnt[r] != '0)) begin
          raw_any = 1'b1;
        end
      end
    end
  end

  // A younger write may not land before an older, longer-latency one to the same register.
  assign waw    = issue_wen && (issue_dst != '0) && (dst_cnt > eff_lat);
  assign live   = issue_valid && !flush;
  assign stall  = live && (raw_any || waw);
  assign accept = live && !stall;

  assign busy_mask[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
    scoreboard_entry #(
      .LAT_BITS(LAT_BITS)
    ) u_entry (
      .clk       (Clk),
      .rst_n     (Rst_n),
      .load_i    (accept && issue_wen && (issue_dst == REG_BITS'(r)) && (eff_lat != '0)),
      .load_val_i(eff_lat),
      .cnt_o     (cnt[r]),
      .busy_o    (busy_mask[r])
    );
  end

  assign stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + PERF_BITS'(1)
                                                      : stall_cnt_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: table of issue vectors with expected
// stall/accept/busy results queued at drive time and compared as the DUT responds.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam int NR = 32;
  localparam int RB = 5;
  localparam int LB = 3;
  localparam int NS = 3;
  localparam int PB = 8;  // narrow perf counter so saturation is reachable quickly

  logic            Clk = 1'b0;
  logic            Rst_n;
  logic            issue_valid, issue_wen, flush;
  logic [RB-1:0]   issue_dst;
  logic [LB-1:0]   issue_lat;
  logic [NS-1:0]   src_valid;
  logic [NS*RB-1:0] src_reg;
  logic            stall, accept;
  logic [NR-1:0]   busy_mask;
  logic [PB-1:0]   stall_count;

  hazard_scoreboard #(
    .NUM_REGS(NR), .REG_BITS(RB), .MAX_LAT(4), .LAT_BITS(LB),
    .NUM_SRC(NS), .PERF_BITS(PB)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n), .issue_valid(issue_valid), .issue_wen(issue_wen),
    .issue_dst(issue_dst), .issue_lat(issue_lat), .src_valid(src_valid),
    .src_reg(src_reg), .flush(flush), .stall(stall), .accept(accept),
    .busy_mask(busy_mask), .stall_count(stall_count)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic             valid;
    logic             wen;
    logic [RB-1:0]    dst;
    logic [LB-1:0]    lat;
    logic [NS-1:0]    srcv;
    logic [NS*RB-1:0] srcs;
    logic             flsh;
    logic             exp_stall;
    logic             exp_accept;
    logic [NR-1:0]    exp_busy;
  } vec_t;

  vec_t          vecs[$];
  vec_t          pend_q[$];
  int            total = 0;
  int            bad = 0;
  int            vec_id = 0;
  logic [PB-1:0] exp_sc = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL v%0d %s: got %0h expected %0h", vec_id, name, act, exp);
    end
  endtask

  function automatic logic [NR-1:0] bit_of(input int r);
    logic [NR-1:0] one;
    one = NR'(1);
    return one << r;
  endfunction

  function automatic logic [NS*RB-1:0] srcs3(input int a, input int b, input int c);
    return {RB'(c), RB'(b), RB'(a)};
  endfunction

  function automatic vec_t mk(input logic valid, input logic wen, input int dst, input int lat,
                              input logic [NS-1:0] srcv, input logic [NS*RB-1:0] srcs,
                              input logic flsh, input logic st, input logic acc,
                              input logic [NR-1:0] busy);
    vec_t v;
    v.valid = valid; v.wen = wen; v.dst = RB'(dst); v.lat = LB'(lat);
    v.srcv = srcv; v.srcs = srcs; v.flsh = flsh;
    v.exp_stall = st; v.exp_accept = acc; v.exp_busy = busy;
    return v;
  endfunction

  // Drive one instruction; comb outputs checked mid-cycle, registered ones after the edge.
  task automatic step(input vec_t v);
    vec_t e;
    @(negedge Clk);
    issue_valid = v.valid; issue_wen = v.wen; issue_dst = v.dst; issue_lat = v.lat;
    src_valid = v.srcv; src_reg = v.srcs; flush = v.flsh;
    pend_q.push_back(v);
    #1;
    e = pend_q[0];
    check("stall", 64'(stall), 64'(e.exp_stall));
    check("accept", 64'(accept), 64'(e.exp_accept));
    if (e.exp_stall && exp_sc != '1) exp_sc = exp_sc + PB'(1);
    @(posedge Clk);
    #1;
    e = pend_q.pop_front();
    check("busy_mask", 64'(busy_mask), 64'(e.exp_busy));
    check("stall_count", 64'(stall_count), 64'(exp_sc));
    vec_id++;
  endtask

  initial begin
    // 1: plain issue without sources
    vecs.push_back(mk(1, 0, 0, 0, 3'b000, srcs3(0, 0, 0), 0, 0, 1, '0));
    // 2: ALU producer r5 then back-to-back reader: one stall cycle
    vecs.push_back(mk(1, 1, 5, LAT_ALU, 3'b000, srcs3(0, 0, 0), 0, 0, 1, bit_of(5)));
    vecs.push_back(mk(1, 0, 0, 0, 3'b001, srcs3(5, 0, 0), 0, 1, 0, '0));
    vecs.push_back(mk(1, 0, 0, 0, 3'b001, srcs3(5, 0, 0), 0, 0, 1, '0));
    // 3: load r8, reader on port 1: two stall cycles
    vecs.push_back(mk(1, 1, 8, LAT_LOAD, 3'b000, srcs3(0, 0, 0), 0, 0, 1, bit_of(8)));
    vecs.push_back(mk(1, 0, 0, 0, 3'b010, srcs3(0, 8, 0), 0, 1, 0, bit_of(8)));
    vecs.push_back(mk(1, 0, 0, 0, 3'b010, srcs3(0, 8, 0), 0, 1, 0, '0));
    vecs.push_back(mk(1, 0, 0, 0, 3'b010, srcs3(0, 8, 0), 0, 0, 1, '0));
    // 4: WAW on r3 (cnt 3) with a lat-1 write; accepted once cnt<=1, reloaded to 1
    vecs.push_back(mk(1, 1, 3, LAT_SAD, 3'b000, srcs3(0, 0, 0), 0, 0, 1, bit_of(3)));
    vecs.push_back(mk(1, 1, 3, LAT_ALU, 3'b000, srcs3(0, 0, 0), 0, 1, 0, bit_of(3)));
    vecs.push_back(mk(1, 1, 3, LAT_ALU, 3'b000, srcs3(0, 0, 0), 0, 1, 0, bit_of(3)));
    vecs.push_back(mk(1, 1, 3, LAT_ALU, 3'b000, srcs3(0, 0, 0), 0, 0, 1, bit_of(3)));
    vecs.push_back(mk(0, 0, 0, 0, 3'b000, srcs3(0, 0, 0), 0, 0, 0, '0));
    // 5: flush over a RAW on r4 (its write to r9 must not land), then dst=0 and src=r0
    vecs.push_back(mk(1, 1, 4, LAT_LOAD, 3'b000, srcs3(0, 0, 0), 0, 0, 1, bit_of(4)));
    vecs.push_back(mk(1, 1, 9, LAT_SAD, 3'b001, srcs3(4, 0, 0), 1, 0, 0, bit_of(4)));
    vecs.push_back(mk(1, 1, 0, LAT_LOAD, 3'b000, srcs3(0, 0, 0), 0, 0, 1, '0));
    vecs.push_back(mk(1, 0, 0, 0, 3'b001, srcs3(0, 0, 0), 0, 0, 1, '0));
    // latency clamp: 7 -> 4 on r10, WAW compares against the clamped value
    vecs.push_back(mk(1, 1, 10, 7, 3'b000, srcs3(0, 0, 0), 0, 0, 1, bit_of(10)));
    vecs.push_back(mk(1, 1, 10, LAT_SAD, 3'b000, srcs3(0, 0, 0), 0, 1, 0, bit_of(10)));
    vecs.push_back(mk(1, 1, 10, 4, 3'b000, srcs3(0, 0, 0), 0, 0, 1, bit_of(10)));
    vecs.push_back(mk(1, 1, 10, 7, 3'b000, srcs3(0, 0, 0), 0, 0, 1, bit_of(10)));
    vecs.push_back(mk(1, 0, 0, 0, 3'b100, srcs3(0, 0, 10), 0, 1, 0, bit_of(10)));
    vecs.push_back(mk(0, 0, 0, 0, 3'b000, srcs3(0, 0, 0), 0, 0, 0, bit_of(10)));
    vecs.push_back(mk(0, 0, 0, 0, 3'b000, srcs3(0, 0, 0), 0, 0, 0, bit_of(10)));
    vecs.push_back(mk(0, 0, 0, 0, 3'b000, srcs3(0, 0, 0), 0, 0, 0, '0));
    // self-dependency sees the old (idle) counter; lat 0 is untracked
    vecs.push_back(mk(1, 1, 6, LAT_LOAD, 3'b001, srcs3(6, 0, 0), 0, 0, 1, bit_of(6)));
    vecs.push_back(mk(0, 0, 0, 0, 3'b000, srcs3(0, 0, 0), 0, 0, 0, bit_of(6)));
    vecs.push_back(mk(0, 0, 0, 0, 3'b000, srcs3(0, 0, 0), 0, 0, 0, '0));
    vecs.push_back(mk(1, 1, 7, LAT_NONE, 3'b000, srcs3(0, 0, 0), 0, 0, 1, '0));

    Rst_n = 1'b0;
    issue_valid = 1'b1; issue_wen = 1'b0; issue_dst = '0; issue_lat = '0;
    src_valid = '0; src_reg = '0; flush = 1'b0;
    #11;
    check("reset busy_mask", 64'(busy_mask), 64'(0));
    check("reset stall_count", 64'(stall_count), 64'(0));
    check("reset stall", 64'(stall), 64'(0));
    check("reset accept", 64'(accept), 64'(1));
    Rst_n = 1'b1;

    foreach (vecs[k]) step(vecs[k]);
    check("stall_count after table", 64'(stall_count), 64'(7));

    // Pump stall cycles through r1 until the counter sits one below saturation.
    while (exp_sc < PB'(8'hFE)) begin
      step(mk(1, 1, 1, 4, 3'b000, srcs3(0, 0, 0), 0, 0, 1, bit_of(1)));
      for (int j = 0; j < 4; j++) begin
        if (exp_sc < PB'(8'hFE))
          step(mk(1, 0, 0, 0, 3'b001, srcs3(1, 0, 0), 0, 1, 0, (j < 3) ? bit_of(1) : '0));
        else
          step(mk(0, 0, 0, 0, 3'b000, srcs3(0, 0, 0), 0, 0, 0, (j < 3) ? bit_of(1) : '0));
      end
    end
    check("stall_count pre-saturation", 64'(stall_count), 64'(8'hFE));

    step(mk(1, 1, 1, 4, 3'b000, srcs3(0, 0, 0), 0, 0, 1, bit_of(1)));
    for (int j = 0; j < 3; j++)
      step(mk(1, 0, 0, 0, 3'b001, srcs3(1, 0, 0), 0, 1, 0, bit_of(1)));
    check("stall_count saturated", 64'(stall_count), 64'(8'hFF));

    // Asynchronous reset mid-countdown, away from any clock edge.
    @(negedge Clk);
    issue_valid = 1'b1; issue_wen = 1'b0; src_valid = 3'b001; src_reg = srcs3(1, 0, 0);
    #1;
    check("pre-reset stall", 64'(stall), 64'(1));
    Rst_n = 1'b0;
    #1;
    check("async reset stall", 64'(stall), 64'(0));
    check("async reset busy_mask", 64'(busy_mask), 64'(0));
    check("async reset stall_count", 64'(stall_count), 64'(0));
    check("async reset accept", 64'(accept), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
